// File: rtl/word_pack64_if.sv
// word_pack64_if: u32 word stream in, packed u64 lane stream out.
// master = word source / lane sink, slave = the packer.
interface word_pack64_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/word_pack64.sv
// word_pack64: packs pairs of u32 words into u64 lanes via a small FIFO.
// Optional PACK64_STATS_EN adds the out_words lane counter port.
module word_pack64 #(
  parameter int OUT_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  word_pack64_if.slave bus,
  output logic         busy
`ifdef PACK64_STATS_EN
  ,
  output logic [15:0]  out_words
`endif
);
  localparam int PW = $clog2(OUT_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(OUT_DEPTH);
  localparam logic [PW-1:0] LAST_P = PW'(OUT_DEPTH - 1);

  typedef enum logic {
    S_LOW  = 1'b0,
    S_HIGH = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_hold;
  logic [31:0]   w_hold_nxt;
  logic [64:0]   r_mem [OUT_DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_full;
  logic          w_empty;
  logic          w_in_hs;
  logic          w_out_hs;
  logic          w_push;
  logic [63:0]   w_push_data;
  logic          w_push_last;
  logic [64:0]   w_head;

  function automatic logic [PW-1:0] f_inc(
    input logic [PW-1:0] p
  );
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  assign w_full   = (r_cnt == FULL_C);
  assign w_empty  = (r_cnt == '0);
  assign w_in_hs  = bus.in_valid & ~w_full;
  assign w_out_hs = bus.out_ready & ~w_empty;
  assign w_head   = r_mem[r_rp];

  assign bus.in_ready  = ~w_full;
  assign bus.out_valid = ~w_empty;
  assign bus.out_data  = w_head[63:0];
  assign bus.out_last  = w_head[64];
  assign busy          = (r_state == S_HIGH) | ~w_empty;

  // Next state, held word and FIFO push request
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_push      = 1'b0;
    w_push_data = '0;
    w_push_last = 1'b0;
    if (w_in_hs) begin
      unique case (r_state)
        S_LOW: begin
          if (bus.in_last) begin
            w_push      = 1'b1;
            w_push_data = {32'h0, bus.in_data};
            w_push_last = 1'b1;
          end else begin
            w_hold_nxt  = bus.in_data;
            w_state_nxt = S_HIGH;
          end
        end
        S_HIGH: begin
          w_push      = 1'b1;
          w_push_data = {bus.in_data, r_hold};
          w_push_last = bus.in_last;
          w_state_nxt = S_LOW;
        end
        default: begin
          w_state_nxt = S_LOW;
        end
      endcase
    end
  end

  // State and held-word registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_LOW;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // Lane FIFO: storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= {w_push_last, w_push_data};
        r_wp        <= f_inc(r_wp);
      end
      if (w_out_hs) begin
        r_rp <= f_inc(r_rp);
      end
      unique case ({w_push, w_out_hs})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

`ifdef PACK64_STATS_EN
  logic [15:0] r_out_words;

  assign out_words = r_out_words;

  // Count accepted output lanes, wrapping at 16 bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_words <= '0;
    end else if (w_out_hs) begin
      r_out_words <= r_out_words + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_word_pack64.sv
// tb_word_pack64: randomized and directed checks of word_pack64
// against a queue-based lane model.
module tb_word_pack64;
  localparam int D = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
`ifdef PACK64_STATS_EN
  logic [15:0] out_words;
`endif

  word_pack64_if bus();

  word_pack64 #(.OUT_DEPTH(D)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .busy (busy)
`ifdef PACK64_STATS_EN
    ,
    .out_words(out_words)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [64:0] mq[$];
  logic [64:0] exp_log[$];
  logic [64:0] dut_log[$];
  bit          m_held = 0;
  logic [31:0] m_hw = '0;
  bit          m_in_hs = 0;
  bit          m_ihs;
  bit          m_ohs;
  logic [15:0] m_words = '0;
  int          m_pushes = 0;
  bit          chk_en = 0;
  bit          rnd_done = 0;

  task automatic chk(input string nm, input logic [64:0] act,
                     input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timeout", nm);
  endtask

  // Reference model: lanes formed from accepted words, FIFO as a queue
  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_held = 0;
      m_hw = '0;
      m_in_hs = 0;
      m_words = '0;
      m_pushes = 0;
    end else begin
      m_ihs = bus.in_valid && (mq.size() < D);
      m_ohs = bus.out_ready && (mq.size() > 0);
      m_in_hs = m_ihs;
      if (m_ohs) begin
        exp_log.push_back(mq.pop_front());
        m_words = m_words + 16'd1;
      end
      if (m_ihs) begin
        if (m_held) begin
          mq.push_back({bus.in_last, bus.in_data, m_hw});
          m_held = 0;
          m_pushes++;
        end else if (bus.in_last) begin
          mq.push_back({1'b1, 32'h0, bus.in_data});
          m_pushes++;
        end else begin
          m_hw = bus.in_data;
          m_held = 1;
        end
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", bus.in_ready, mq.size() < D);
      chk("out_valid", bus.out_valid, mq.size() > 0);
      chk("busy", busy, m_held || (mq.size() > 0));
      if (mq.size() > 0) begin
        chk("out_data", bus.out_data, mq[0][63:0]);
        chk("out_last", bus.out_last, mq[0][64]);
      end
`ifdef PACK64_STATS_EN
      chk("out_words", out_words, m_words);
`endif
      if (rst_n && bus.out_valid && bus.out_ready)
        dut_log.push_back({bus.out_last, bus.out_data});
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] d, input bit l);
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_last = l;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
      if (m_in_hs) begin
        bus.in_valid = 1'b0;
        return;
      end
    end
    bus.in_valid = 1'b0;
    timeout("send");
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (mq.size() == 0 && !m_held) return;
      @(posedge clk);
      #1;
    end
    timeout("drain");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int eb;
    int db;
    logic [63:0] head;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_busy", busy, 0);
`ifdef PACK64_STATS_EN
    chk("rst_out_words", out_words, 0);
`endif
    chk_en = 1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Two words -> one lane, latency 1
    bus.out_ready = 1'b1;
    send(32'h11111111, 0);
    send(32'h22222222, 1);
    @(negedge clk);
    chk("p2_valid", bus.out_valid, 1);
    chk("p2_data", bus.out_data, 64'h2222222211111111);
    chk("p2_last", bus.out_last, 1);
    chk("p2_model", mq[0], {1'b1, 64'h2222222211111111});
    drain();

    // Odd-length array pads the final lane
    eb = exp_log.size();
    db = dut_log.size();
    send(32'hA, 0);
    send(32'hB, 0);
    send(32'hC, 1);
    drain();
    chk("odd_n_model", exp_log.size() - eb, 2);
    chk("odd_n_dut", dut_log.size() - db, 2);
    chk("odd_m0", exp_log[eb], {1'b0, 64'h0000000B0000000A});
    chk("odd_m1", exp_log[eb+1], {1'b1, 64'h000000000000000C});
    chk("odd_d0", dut_log[db], {1'b0, 64'h0000000B0000000A});
    chk("odd_d1", dut_log[db+1], {1'b1, 64'h000000000000000C});

    // Backpressure: fill FIFO, hold, then release
    eb = exp_log.size();
    db = dut_log.size();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2 * D; i++) send(32'h100 + i, 0);
    @(negedge clk);
    chk("bp_in_ready", bus.in_ready, 0);
    head = bus.out_data;
    chk("bp_head", head, 64'h0000010100000100);
    cyc(3);
    @(negedge clk);
    chk("bp_stable", bus.out_data, head);
    fork
      send(32'h1FF, 1);
      begin
        cyc(3);
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_n_dut", dut_log.size() - db, D + 1);
    chk("bp_first", dut_log[db], {1'b0, 64'h0000010100000100});
    chk("bp_lastlane", dut_log[dut_log.size()-1],
        {1'b1, 32'h0, 32'h1FF});

    // Full FIFO with simultaneous pop and offered word
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2 * D; i++) send(32'h300 + i, 0);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 32'h33;
    bus.in_last = 1'b1;
    @(negedge clk);
    chk("full_in_ready", bus.in_ready, 0);
    @(negedge clk);
    chk("pop_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    drain();
    chk("full_lastlane", dut_log[dut_log.size()-1],
        {1'b1, 32'h0, 32'h33});

    // Reset mid-array discards the held word
    eb = exp_log.size();
    db = dut_log.size();
    send(32'h5, 0);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    send(32'h7, 1);
    drain();
    chk("rst_mid_n", dut_log.size() - db, 1);
    chk("rst_mid_lane", dut_log[dut_log.size()-1],
        {1'b1, 64'h0000000000000007});
    chk("rst_mid_model", exp_log.size() - eb, 1);
    @(negedge clk);
    chk("rst_mid_busy", busy, 0);

    // Randomized traffic with random backpressure
    eb = exp_log.size();
    db = dut_log.size();
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) cyc(1);
          send($urandom, $urandom_range(0, 4) == 0);
        end
        send($urandom, 1);
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    cyc(1);
    chk("rnd_count", dut_log.size() - db, exp_log.size() - eb);
    for (int i = 0; i < exp_log.size() - eb; i++) begin
      if (db + i < dut_log.size())
        chk("rnd_lane", dut_log[db+i], exp_log[eb+i]);
    end

`ifdef PACK64_STATS_EN
    // Lane counter wraps at 16 bits
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_last = 1'b1;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 70000 && m_pushes < 65537; k++) begin
      bus.in_data = $urandom;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("stats_pushes", m_pushes, 65537);
    drain();
    cyc(1);
    @(negedge clk);
    chk("stats_wrap", out_words, 16'd1);
`endif

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/word_pack64.md
WORD_PACK64 -- requirements
Module: word_pack64

Interface
REQ-001 The block SHALL have parameter: OUT_DEPTH, 2, output FIFO entries (legal values 2 or 4).
REQ-002 The block SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port: rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 The block SHALL have port: in_valid  input  1  upstream byte-swap stage presents a u32 word.
REQ-005 The block SHALL have port: in_ready  output  1  block accepts in_data this cycle.
REQ-006 The block SHALL have port: in_data  input  32  byte-swapped u32 word.
REQ-007 The block SHALL have port: in_last  input  1  final word of the current array.
REQ-008 The block SHALL have port: out_valid  output  1  FIFO head holds a packed u64.
REQ-009 The block SHALL have port: out_ready  input  1  downstream consumer accepts out_data.
REQ-010 The block SHALL have port: out_data  output  64  packed u64 lane.
REQ-011 The block SHALL have port: out_last  output  1  out_data is the final lane of the array.
REQ-012 The block SHALL have port: busy  output  1  high when a low word is held or the FIFO is non-empty.
REQ-013 The block SHALL have port: out_words  output  16  count of accepted output lanes (present only under PACK64_STATS_EN).

Function
REQ-014 The block SHALL treat an input handshake as in_valid & in_ready and an output handshake as out_valid & out_ready, both evaluated at the rising clk edge.
REQ-015 in_ready SHALL equal NOT fifo_full, registered-state only, with no combinational path from out_ready or in_valid.
REQ-016 The state machine SHALL have two states: LOW (no held word) and HIGH (low word held in hold_r).
REQ-017 In LOW, an input handshake with in_last=0 SHALL latch in_data into hold_r and move to HIGH; nothing is pushed.
REQ-018 In LOW, an input handshake with in_last=1 SHALL push {32'h0, in_data} with last=1 and stay in LOW (odd-length pad).
REQ-019 In HIGH, an input handshake SHALL push {in_data, hold_r} with last=in_last and return to LOW.
REQ-020 Packing SHALL place the first word in bits [31:0] and the second in bits [63:32], with no further byte reordering.
REQ-021 A pushed lane SHALL appear with out_valid=1 on the cycle after the completing input handshake (latency 1 when the FIFO was empty).
REQ-022 The FIFO SHALL be first-in first-out; out_data and out_last SHALL be driven from the FIFO head and held stable while out_valid=1 and out_ready=0.
REQ-023 A simultaneous push and pop SHALL leave the occupancy unchanged; when the FIFO is full, in_ready=0 even if a pop occurs that cycle.
REQ-024 FIFO read and write pointers SHALL wrap modulo OUT_DEPTH.
REQ-025 A pop from an empty FIFO SHALL NOT occur; out_valid=0 whenever the FIFO is empty.

Reset
REQ-026 While rst_n=0 at a rising edge: state=LOW, hold_r=0, FIFO empty, out_valid=0, out_data=0, out_last=0, busy=0, in_ready=1 on the following cycle, and out_words=0.
REQ-027 A reset asserted mid-array SHALL discard the held word and all FIFO contents, with no lane emitted for them.

Configuration
REQ-028 Macro PACK64_STATS_EN defined: out_words SHALL exist and increment by 1 on every output handshake, wrapping from 16'hFFFF to 0.
REQ-029 Macro PACK64_STATS_EN undefined: the out_words port and its counter SHALL be absent, with all other behaviour identical.

Verification
REQ-030 Reset then words 0x11111111, 0x22222222 (last) with out_ready=1 -> one lane 0x2222222211111111, out_last=1, emitted 1 cycle after the second handshake.
REQ-031 Three words 0xA, 0xB, 0xC (last on 0xC) -> lanes 0x0000000B0000000A (last=0), then 0x000000000000000C (last=1).
REQ-032 out_ready=0 with 2*OUT_DEPTH+1 words streamed -> in_ready drops after OUT_DEPTH lanes are queued; out_data stays stable; after out_ready=1 all lanes drain in order with no loss.
REQ-033 FIFO full with out_ready=1 and in_valid=1 in the same cycle -> pop occurs, no push that cycle, in_ready=1 next cycle.
REQ-034 One word 0x5 (last=0) accepted, then rst_n=0 for 1 cycle, then 0x7 (last=1) -> only lane 0x0000000000000007 with last=1 is emitted; busy=0 after the drain.
REQ-035 With PACK64_STATS_EN, 65537 output handshakes -> out_words=1.
